// File: rtl/irq_request_latch.sv
// irq_request_latch: synchronises N asynchronous interrupt lines, detects
// rising edges and holds each edge as a pending bit until it is acknowledged.
// The unmasked pending vector and its OR drive the downstream priority
// encoder (I and en); the encoder's Y comes back as ack_idx.
//
// Optional feature: define IRQ_OVF_EN to build the sticky lost-edge flags
// (ovf_q / ovf_clr). Without it ovf_q is tied to zero and ovf_clr is ignored,
// but both ports stay on the interface.
module irq_request_latch #(
  parameter int N           = 8,
  parameter int IDX_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     irq_in,
  input  logic             mask_wr,
  input  logic [N-1:0]     mask_din,
  output logic [N-1:0]     mask_q,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [N-1:0]     pending_q,
  output logic [N-1:0]     req_vec,
  output logic             req_en,
  input  logic             ovf_clr,
  output logic [N-1:0]     ovf_q
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] hist_q;
  logic [N-1:0] sync_lvl;
  logic [N-1:0] rise;
  logic [N-1:0] clr_vec;
  logic [N-1:0] pending_d;

  // Synchroniser chain: the last stage is the metastability-safe line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Edge history: cleared by reset so a line held high through reset gives one rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= sync_lvl;
    end
  end

  assign rise = sync_lvl & ~hist_q;

  // Decode the acknowledge into a one-hot clear; out-of-range indices clear nothing.
  always_comb begin
    clr_vec = '0;
    if (ack && (32'(ack_idx) < N)) begin
      clr_vec[ack_idx] = 1'b1;
    end
  end

  // A new edge beats a clear of the same bit, so no request is ever dropped.
  assign pending_d = (pending_q & ~clr_vec) | rise;

  // Pending register: masked lines still latch, the mask only gates req_vec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Mask register, loaded on request; takes effect on req_vec the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (mask_wr) begin
      mask_q <= mask_din;
    end
  end

  assign req_vec = pending_q & ~mask_q;
  assign req_en  = |req_vec;

`ifdef IRQ_OVF_EN
  // Sticky overflow: an edge arrived on a bit that was already pending and not
  // being serviced, so one request was merged away. A new set beats ovf_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~clr_vec);
    end
  end
`else
  logic ovf_clr_unused;

  assign ovf_q          = '0;
  assign ovf_clr_unused = ovf_clr;
`endif

endmodule

// File: tb/tb_irq_request_latch.sv
// Self-checking bench for irq_request_latch (N=8, SYNC_STAGES=2).
// Stimulus computes the expected outputs from a history of sampled input
// levels and pushes them into a queue; a monitor pops and compares one entry
// after every clock edge that has a pending expectation.
module tb_irq_request_latch;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_din = '0;
  logic [7:0] mask_q;
  logic       ack = 1'b0;
  logic [2:0] ack_idx = '0;
  logic [7:0] pending_q;
  logic [7:0] req_vec;
  logic       req_en;
  logic       ovf_clr = 1'b0;
  logic [7:0] ovf_q;

  typedef struct {
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] req;
    logic       en;
    logic [7:0] ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] samp[$];
  logic [7:0] m_pend, m_mask, m_ovf;
  int         n_cmp = 0;
  int         n_bad = 0;

  irq_request_latch #(.N(8), .IDX_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
    .mask_wr(mask_wr), .mask_din(mask_din), .mask_q(mask_q),
    .ack(ack), .ack_idx(ack_idx),
    .pending_q(pending_q), .req_vec(req_vec), .req_en(req_en),
    .ovf_clr(ovf_clr), .ovf_q(ovf_q)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Clear the reference model as reset does: no pending, no mask, no history.
  task automatic model_reset();
    m_pend = '0;
    m_mask = '0;
    m_ovf  = '0;
    samp.delete();
    repeat (4) samp.push_back(8'h00);
  endtask

  // Drive inputs for the coming edge and queue what the outputs must be after it.
  // The logic sees the line level sampled two edges earlier; an edge is a
  // 0->1 change between two consecutive such samples.
  task automatic drive_and_push(input logic [7:0] irq, input logic mwr, input logic [7:0] mdin,
                                input logic a, input int aidx, input logic oc);
    logic [7:0] seen_now, seen_prev, rise, np, no;
    exp_t e;
    irq_in   = irq;
    mask_wr  = mwr;
    mask_din = mdin;
    ack      = a;
    ack_idx  = 3'(aidx);
    ovf_clr  = oc;
    samp.push_front(irq);
    seen_now  = samp[2];
    seen_prev = samp[3];
    void'(samp.pop_back());
    rise = seen_now & ~seen_prev;
    np = m_pend;
    no = m_ovf;
`ifdef IRQ_OVF_EN
    if (oc) no = '0;
`endif
    for (int i = 0; i < N; i++) begin
      bit serviced;
      serviced = a && (aidx == i);
      if (rise[i]) begin
        np[i] = 1'b1;
`ifdef IRQ_OVF_EN
        if (m_pend[i] && !serviced) no[i] = 1'b1;
`endif
      end else if (serviced) begin
        np[i] = 1'b0;
      end
    end
    m_pend = np;
    m_ovf  = no;
    if (mwr) m_mask = mdin;
    e.pend = m_pend;
    e.mask = m_mask;
    e.req  = m_pend & ~m_mask;
    e.en   = (e.req != 8'h00);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] irq, input logic mwr = 1'b0,
                               input logic [7:0] mdin = 8'h00, input logic a = 1'b0,
                               input int aidx = 0, input logic oc = 1'b0);
    @(negedge clk);
    drive_and_push(irq, mwr, mdin, a, aidx, oc);
  endtask

  // Assert reset part-way through a cycle, confirm outputs drop at once, then
  // release before the next edge with the line levels left as they were.
  task automatic pulseReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst pending_q", pending_q, 0);
    check("rst req_vec", req_vec, 0);
    check("rst req_en", req_en, 0);
    check("rst mask_q", mask_q, 0);
    check("rst ovf_q", ovf_q, 0);
    #1 rst_n = 1'b1;
    model_reset();
    drive_and_push(irq_in, 1'b0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  // Directed spot check of an output just after the most recent edge.
  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    check(name, act, req);
  endtask

  // Monitor: one queued expectation per clock edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb pending_q", pending_q, e.pend);
        check("sb mask_q", mask_q, e.mask);
        check("sb req_vec", req_vec, e.req);
        check("sb req_en", req_en, e.en);
        check("sb ovf_q", ovf_q, e.ovf);
      end
    end
  end

  initial begin
    logic [7:0] cur;
    model_reset();
    // 1: reset held with quiet lines
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold pending_q", pending_q, 0);
      checkOutput("hold req_en", req_en, 0);
    end
    pulseReset();
    repeat (3) applyStimulus(8'h00);

    // 2: single line, then acknowledge it
    repeat (3) applyStimulus(8'h04);
    @(posedge clk); #2;
    checkOutput("t2 req_vec", req_vec, 8'h04);
    checkOutput("t2 req_en", req_en, 1);
    applyStimulus(8'h04, 0, 0, 1, 2);
    @(posedge clk); #2;
    checkOutput("t2 ack req_vec", req_vec, 8'h00);
    checkOutput("t2 ack req_en", req_en, 0);
    repeat (3) applyStimulus(8'h00);

    // 3: two lines; ack of a non-pending bit changes nothing
    repeat (3) applyStimulus(8'h24);
    @(posedge clk); #2;
    checkOutput("t3 req_vec", req_vec, 8'h24);
    applyStimulus(8'h24, 0, 0, 1, 5);
    @(posedge clk); #2;
    checkOutput("t3 ack5", req_vec, 8'h04);
    applyStimulus(8'h24, 0, 0, 1, 7);
    @(posedge clk); #2;
    checkOutput("t3 ack7", req_vec, 8'h04);
    applyStimulus(8'h24, 0, 0, 1, 2);
    @(posedge clk); #2;
    checkOutput("t3 ack2", req_vec, 8'h00);
    repeat (3) applyStimulus(8'h00);

    // 4: masked line still latches; unmasking exposes it
    applyStimulus(8'h00, 1, 8'hFF);
    repeat (3) applyStimulus(8'h80);
    @(posedge clk); #2;
    checkOutput("t4 pending_q", pending_q, 8'h80);
    checkOutput("t4 req_vec", req_vec, 8'h00);
    checkOutput("t4 req_en", req_en, 0);
    applyStimulus(8'h80, 1, 8'h00);
    @(posedge clk); #2;
    checkOutput("t4 unmask req_vec", req_vec, 8'h80);
    checkOutput("t4 unmask req_en", req_en, 1);
    applyStimulus(8'h00, 0, 0, 1, 7);
    repeat (3) applyStimulus(8'h00);

    // 5: set beats clear on the same bit; second edge on a pending bit
    repeat (3) applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'h04);
    applyStimulus(8'h04);
    applyStimulus(8'h04, 0, 0, 1, 2);
    @(posedge clk); #2;
    checkOutput("t5 set wins", pending_q[2], 1);
    checkOutput("t5 no ovf on serviced", ovf_q, 8'h00);
    repeat (3) applyStimulus(8'h0C);
    applyStimulus(8'h04);
    repeat (3) applyStimulus(8'h0C);
    @(posedge clk); #2;
`ifdef IRQ_OVF_EN
    checkOutput("t5 ovf", ovf_q, 8'h08);
`else
    checkOutput("t5 ovf", ovf_q, 8'h00);
`endif
    applyStimulus(8'h0C, 0, 0, 0, 0, 1);
    @(posedge clk); #2;
    checkOutput("t5 ovf_clr", ovf_q, 8'h00);
    applyStimulus(8'h00, 0, 0, 1, 2);
    applyStimulus(8'h00, 0, 0, 1, 3);
    repeat (3) applyStimulus(8'h00);

    // 6: reset mid-operation with one line still high
    repeat (3) applyStimulus(8'h11);
    applyStimulus(8'h01);
    @(posedge clk); #2;
    checkOutput("t6 pending before", pending_q, 8'h11);
    pulseReset();
    repeat (4) applyStimulus(8'h01);
    @(posedge clk); #2;
    checkOutput("t6 pending after", pending_q, 8'h01);
    applyStimulus(8'h00, 0, 0, 1, 0);
    repeat (3) applyStimulus(8'h00);

    // Randomised traffic against the model
    cur = 8'h00;
    for (int c = 0; c < 600; c++) begin
      logic [7:0] tog;
      tog = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cur = cur ^ tog;
      if (c == 300) begin
        pulseReset();
      end else begin
        applyStimulus(cur, ($urandom_range(7) == 0), 8'($urandom),
                      ($urandom_range(1) == 1), int'($urandom_range(7)),
                      ($urandom_range(9) == 0));
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
